// File: rtl/uart_define_pkg.sv
// Shared UART receiver definitions: FSM encodings, oversampling constants
// and small bit-level helpers used by the receiver and its sampler.
package uart_define;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int OVERSAMPLE = 32'sd16;
    localparam int FRAME_BITS = 32'sd11;
    // start + parity + stop surround the data bits
    localparam int DATA_BITS  = FRAME_BITS - 32'sd3;

    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_LAST  = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_fail(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: RXD synchronizer, oversample tick divider and
// the 2-of-3 majority voter over the mid-bit samples.
module uart_rx_sampler
    import uart_define::*;
#(
    parameter int SAMPLE_DIV = 32'sd4
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       rx_en_i,
    input  logic       rxd_i,
    input  logic       clr_div_i,
    input  logic [3:0] cnt_i,
    output logic       fall_o,
    output logic       tick_o,
    output logic       vote_o
);

    localparam int DIV_W = (SAMPLE_DIV > 32'sd1) ? $clog2(SAMPLE_DIV) : 32'sd1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 32'sd1);

    logic             meta_q, sync_q, prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             s_first_q, s_mid_q;
    logic             s_first_d, s_mid_d;

    // Divider and sample-capture next state
    always_comb begin
        div_d     = div_q;
        s_first_d = s_first_q;
        s_mid_d   = s_mid_q;
        if (!rx_en_i || clr_div_i) begin
            div_d = '0;
        end else if (div_q == DIV_MAX) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1'b1);
        end
        if (tick_o && (cnt_i == SMP_FIRST)) begin
            s_first_d = sync_q;
        end else if (tick_o && (cnt_i == SMP_MID)) begin
            s_mid_d = sync_q;
        end else begin
            s_first_d = s_first_q;
        end
    end

    // Synchronizer, edge history, divider and sample registers
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            prev_q    <= 1'b1;
            div_q     <= '0;
            s_first_q <= 1'b1;
            s_mid_q   <= 1'b1;
        end else begin
            meta_q    <= rxd_i;
            sync_q    <= meta_q;
            prev_q    <= sync_q;
            div_q     <= div_d;
            s_first_q <= s_first_d;
            s_mid_q   <= s_mid_d;
        end
    end

    assign fall_o = prev_q & ~sync_q;
    assign tick_o = (div_q == DIV_MAX);
    // third vote is the live sample at the decision tick
    assign vote_o = maj3(s_first_q, s_mid_q, sync_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, even parity, one stop bit, 16x oversampling,
// with a single-entry holding register and valid/ready handshake.
module uart_rx
    import uart_define::*;
#(
    parameter int SAMPLE_DIV = 32'sd4,
    parameter int OVERSAMPLE = uart_define::OVERSAMPLE
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       RXD,
    input  logic       rx_ready,
    output logic [7:0] rxd_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 32'sd1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 32'sd1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bit_q, par_bit_d;
    logic [7:0] data_q, data_d;
    logic       perr_q, perr_d, ferr_q, ferr_d;
    logic       valid_q, valid_d, ovr_q, ovr_d;

    logic fall_s, tick_s, vote_s;
    logic sample_pt_s, bit_end_s;
    logic start_det_s, shift_en_s, par_en_s, frame_done_s;

    uart_rx_sampler #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_sampler (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .rx_en_i   (rx_en),
        .rxd_i     (RXD),
        .clr_div_i (start_det_s),
        .cnt_i     (cnt_q),
        .fall_o    (fall_s),
        .tick_o    (tick_s),
        .vote_o    (vote_s)
    );

    // FSM state register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; STOP leaves at the decision tick so a new start is seen early
    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) state_d = ST_START;
                    else        state_d = ST_IDLE;
                end
                ST_START: begin
                    if (sample_pt_s && vote_s) state_d = ST_IDLE;
                    else if (bit_end_s)        state_d = ST_DATA;
                    else                       state_d = ST_START;
                end
                ST_DATA: begin
                    if (bit_end_s && (bit_idx_q == LAST_BIT)) state_d = ST_PARITY;
                    else                                      state_d = ST_DATA;
                end
                ST_PARITY: begin
                    if (bit_end_s) state_d = ST_STOP;
                    else           state_d = ST_PARITY;
                end
                ST_STOP: begin
                    if (sample_pt_s) state_d = ST_IDLE;
                    else             state_d = ST_STOP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output strobes
    always_comb begin
        start_det_s  = 1'b0;
        shift_en_s   = 1'b0;
        par_en_s     = 1'b0;
        frame_done_s = 1'b0;
        sample_pt_s  = tick_s && (cnt_q == SMP_LAST);
        bit_end_s    = tick_s && (cnt_q == LAST_CNT);
        if (rx_en) begin
            case (state_q)
                ST_IDLE:   start_det_s  = fall_s;
                ST_DATA:   shift_en_s   = sample_pt_s;
                ST_PARITY: par_en_s     = sample_pt_s;
                ST_STOP:   frame_done_s = sample_pt_s;
                default:   start_det_s  = 1'b0;
            endcase
        end else begin
            start_det_s = 1'b0;
        end
    end

    // Datapath and holding-register next state
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = valid_q;
        ovr_d     = frame_done_s && valid_q && !rx_ready;

        if (!rx_en || (state_q == ST_IDLE)) cnt_d = 4'd0;
        else if (tick_s)                    cnt_d = cnt_q + 4'd1;
        else                                cnt_d = cnt_q;

        if (state_q != ST_DATA) bit_idx_d = 3'd0;
        else if (bit_end_s)     bit_idx_d = bit_idx_q + 3'd1;
        else                    bit_idx_d = bit_idx_q;

        if (shift_en_s) shift_d = {vote_s, shift_q[7:1]};
        else            shift_d = shift_q;

        if (par_en_s) par_bit_d = vote_s;
        else          par_bit_d = par_bit_q;

        // a completing frame may load in the same cycle the old byte is taken
        if (frame_done_s && (!valid_q || rx_ready)) begin
            data_d  = shift_q;
            perr_d  = parity_fail(shift_q, par_bit_q);
            ferr_d  = ~vote_s;
            valid_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Datapath and holding registers
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bit_q <= 1'b0;
            data_q    <= 8'h00;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rxd_out    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames, checked
// every cycle against a queue of expected held bytes.
module tb_uart_rx;

    localparam int BIT_CYC = 64;

    logic       mclk = 1'b0;
    logic       rst_n, rx_en, RXD, rx_ready;
    logic [7:0] rxd_out;
    logic       rx_valid, parity_err, frame_err, overrun;

    always #5 mclk = ~mclk;

    uart_rx #(.SAMPLE_DIV(4)) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .RXD        (RXD),
        .rx_ready   (rx_ready),
        .rxd_out    (rxd_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0, bad = 0;
    int         ovr_seen = 0, ovr_exp = 0;
    logic       ovr_prev = 1'b0;
    logic [7:0] last_d = 8'h00;
    logic       last_pe = 1'b0, last_fe = 1'b0;
    int         vld_run = 0, last_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Per-cycle comparison of the DUT against the expected-byte queue
    always @(negedge mclk) begin
        if (!rst_n) begin
            ovr_prev = 1'b0;
            vld_run  = 0;
        end else begin
            if (overrun) begin
                ovr_seen++;
                check("overrun_width", {31'd0, ovr_prev}, 32'd0);
            end
            ovr_prev = overrun;
            if (rx_valid) begin
                vld_run++;
                check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("rxd_out", {24'd0, rxd_out}, {24'd0, exp_q[0].d});
                    check("parity_err", {31'd0, parity_err}, {31'd0, exp_q[0].pe});
                    check("frame_err", {31'd0, frame_err}, {31'd0, exp_q[0].fe});
                    last_d  = rxd_out;
                    last_pe = parity_err;
                    last_fe = frame_err;
                    if (rx_ready) begin
                        void'(exp_q.pop_front());
                        last_run = vld_run;
                        vld_run  = 0;
                    end
                end
            end else begin
                vld_run = 0;
            end
        end
    end

    task automatic drive(input logic b, input int n);
        RXD = b;
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        drive(1'b0, BIT_CYC);
        for (int i = 0; i < nbits; i++) drive(d[i], BIT_CYC);
    endtask

    // Model decides at the stop bit whether the frame will be held or dropped
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v);
        logic par;
        exp_t e;
        par = (^d) ^ flip;
        send_bits(d, 8);
        drive(par, BIT_CYC);
        if (exp_q.size() != 0 && !rx_ready) begin
            ovr_exp++;
        end else begin
            e.d  = d;
            e.pe = ^{d, par};
            e.fe = (stop_v == 1'b0);
            exp_q.push_back(e);
        end
        drive(stop_v, BIT_CYC);
        RXD = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge mclk);
            n++;
        end
        #1;
        check({name, "_drain"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr_base;
        exp_t e;
        logic [7:0] rd;
        rst_n = 1'b0; rx_en = 1'b1; RXD = 1'b1; rx_ready = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("rst_rxd_out", {24'd0, rxd_out}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 10);

        send_frame(8'hA5, 1'b0, 1'b1);
        drive(1'b1, 16);
        wait_drain("a5");
        check("a5_data", {24'd0, last_d}, 32'h0000_00A5);
        check("a5_perr", {31'd0, last_pe}, 32'd0);
        check("a5_ferr", {31'd0, last_fe}, 32'd0);
        check("a5_valid_len", last_run, 32'd1);

        send_frame(8'h3C, 1'b1, 1'b1);
        drive(1'b1, 16);
        wait_drain("3c");
        check("3c_data", {24'd0, last_d}, 32'h0000_003C);
        check("3c_perr", {31'd0, last_pe}, 32'd1);

        send_frame(8'h55, 1'b0, 1'b0);
        drive(1'b1, 2 * BIT_CYC);
        wait_drain("55");
        check("55_ferr", {31'd0, last_fe}, 32'd1);
        send_frame(8'h0F, 1'b0, 1'b1);
        drive(1'b1, 16);
        wait_drain("0f");
        check("0f_data", {24'd0, last_d}, 32'h0000_000F);
        check("0f_ferr", {31'd0, last_fe}, 32'd0);
        check("0f_perr", {31'd0, last_pe}, 32'd0);

        rx_ready = 1'b0;
        ovr_base = ovr_seen;
        send_frame(8'h11, 1'b0, 1'b1);
        drive(1'b1, 16);
        send_frame(8'h22, 1'b0, 1'b1);
        drive(1'b1, 16);
        check("ovr_keep_data", {24'd0, rxd_out}, 32'h0000_0011);
        check("ovr_keep_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_pulses", ovr_seen - ovr_base, 32'd1);
        send_bits(8'h05, 3);
        rx_en = 1'b0;
        drive(1'b1, 20);
        rx_en = 1'b1;
        drive(1'b1, 2 * BIT_CYC);
        check("abort_keep_data", {24'd0, rxd_out}, 32'h0000_0011);
        check("abort_keep_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        wait_drain("11");
        drive(1'b1, 4);
        check("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);

        drive(1'b0, 20);
        drive(1'b1, 2 * BIT_CYC);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        drive(1'b1, 16);
        wait_drain("81");
        check("81_data", {24'd0, last_d}, 32'h0000_0081);

        e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
        exp_q.push_back(e);
        drive(1'b0, 12 * BIT_CYC);
        drive(1'b1, 2 * BIT_CYC);
        wait_drain("break");
        check("break_data", {24'd0, last_d}, 32'd0);
        check("break_ferr", {31'd0, last_fe}, 32'd1);

        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        drive(1'b1, 16);
        send_bits(8'hC3, 4);
        drive(1'b0, BIT_CYC / 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", {24'd0, rxd_out}, 32'd0);
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_perr", {31'd0, parity_err}, 32'd0);
        check("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
        exp_q.delete();
        rx_ready = 1'b1;
        RXD = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2 * BIT_CYC);
        send_frame(8'h7E, 1'b0, 1'b1);
        drive(1'b1, 16);
        wait_drain("7e");
        check("7e_data", {24'd0, last_d}, 32'h0000_007E);

        for (int k = 0; k < 12; k++) begin
            rd = 8'($urandom);
            send_frame(rd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0));
            drive(1'b1, $urandom_range(1, 40));
            wait_drain("rand");
        end

        drive(1'b1, 16);
        check("overrun_total", ovr_seen, ovr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
